// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle CPU control unit: FSM state codes,
// opcode constants, branch condition codes, the pass-through ALU operation
// and a small helper that evaluates a branch condition against a flag set.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // State codes are visible on the state output, so they are fixed values.
    typedef enum logic [3:0] {
        ST_RESET   = 4'h0,
        ST_FETCH   = 4'h1,
        ST_DECODE  = 4'h2,
        ST_EX_ALU  = 4'h3,
        ST_EX_LD   = 4'h4,
        ST_EX_ST   = 4'h5,
        ST_EX_BR   = 4'h6,
        ST_EX_JR   = 4'h7,
        ST_HALT    = 4'h8,
        ST_ILLEGAL = 4'h9
    } state_t;

    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BR   = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] COND_ALWAYS = 4'h0;
    localparam logic [3:0] COND_Z      = 4'h1;
    localparam logic [3:0] COND_N      = 4'h2;
    localparam logic [3:0] COND_C      = 4'h3;

    localparam logic [3:0] ALU_PASS_S = 4'h0;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
    } flags_t;

    // Unlisted condition codes mean "never taken".
    function automatic logic cond_true(input logic [3:0] cond, input flags_t f);
        logic t;
        case (cond)
            COND_ALWAYS: t = 1'b1;
            COND_Z:      t = f.z;
            COND_N:      t = f.n;
            COND_C:      t = f.c;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_cu_decode.sv
// ---------------------------------------------------------------------------
// cu_decode
// Combinational instruction decode for the control unit: maps the opcode in
// IR to the execute state that follows DECODE, and evaluates the branch
// condition field against the flags captured during DECODE.
// Ports:
//   ir       in   16  instruction register contents
//   flags    in   3   flags sampled in DECODE (registered in the top)
//   dec_next out  4   state to enter after DECODE
//   br_taken out  1   branch condition true
// ---------------------------------------------------------------------------
module cu_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    input  flags_t      flags,
    output state_t      dec_next,
    output logic        br_taken
);

    always_comb begin
        dec_next = ST_ILLEGAL;
        if (ir[15] == 1'b0) begin
            // Any opcode with the top bit clear is an ALU operation.
            dec_next = ST_EX_ALU;
        end else begin
            case (ir[15:12])
                OP_LD:   dec_next = ST_EX_LD;
                OP_ST:   dec_next = ST_EX_ST;
                OP_BR:   dec_next = ST_EX_BR;
                OP_JR:   dec_next = ST_EX_JR;
                OP_HALT: dec_next = ST_HALT;
                default: dec_next = ST_ILLEGAL;
            endcase
        end
    end

    assign br_taken = cond_true(ir[11:8], flags);

endmodule

// File: rtl/cpu_cu.sv
// ---------------------------------------------------------------------------
// cpu_cu
// Control unit for a small multi-cycle CPU. Each instruction runs
// FETCH -> DECODE -> one EX_* state. HALT and ILLEGAL are terminal until
// reset. All outputs are decoded from the registered state, the IR fields
// and the flags captured in DECODE, never from the live C/N/Z inputs.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   IR [15:0], C, N, Z          instruction and datapath flags
//   W_En, W_Adr, R_Adr, S_Adr   register-file write enable / addresses
//   sel, alu_op                 S operand select (1 = memory), ALU op
//   adr_sel, ld_en, pc_inc,     memory address select (1 = register),
//   pc_sel, ir_en               PC load/increment/source, IR load
//   mr_en, mw_en                memory read/write strobes
//   state, halted, illegal      FSM state code and status
// ---------------------------------------------------------------------------
module cpu_cu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        W_En,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic        sel,
    output logic [3:0]  alu_op,
    output logic        adr_sel,
    output logic        ld_en,
    output logic        pc_inc,
    output logic        pc_sel,
    output logic        ir_en,
    output logic        mr_en,
    output logic        mw_en,
    output logic [3:0]  state,
    output logic        halted,
    output logic        illegal
);

    state_t state_q, state_d;
    flags_t flags_q, flags_d;
    state_t dec_next;
    logic   br_taken;

    cu_decode u_decode (
        .ir       (IR),
        .flags    (flags_q),
        .dec_next (dec_next),
        .br_taken (br_taken)
    );

    // Flags are captured on the edge that leaves DECODE so the branch in
    // EX_BR sees the flags as they were while the instruction was decoded.
    always_comb begin
        flags_d = flags_q;
        if (state_q == ST_DECODE) begin
            flags_d = '{c: C, n: N, z: Z};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:   state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE:  state_d = dec_next;
            ST_EX_ALU,
            ST_EX_LD,
            ST_EX_ST,
            ST_EX_BR,
            ST_EX_JR:   state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_ILLEGAL;
        endcase
    end

    // Output decode
    always_comb begin
        W_En    = 1'b0;
        sel     = 1'b0;
        alu_op  = ALU_PASS_S;
        adr_sel = 1'b0;
        ld_en   = 1'b0;
        pc_inc  = 1'b0;
        pc_sel  = 1'b0;
        ir_en   = 1'b0;
        mr_en   = 1'b0;
        mw_en   = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        // Register addresses always follow the IR fields; the enables decide
        // whether they matter. Register 0 gets no special treatment.
        W_Adr   = IR[8:6];
        R_Adr   = IR[5:3];
        S_Adr   = IR[2:0];
        case (state_q)
            ST_FETCH: begin
                mr_en  = 1'b1;
                ir_en  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_EX_ALU: begin
                W_En   = 1'b1;
                alu_op = IR[14:11];
            end
            ST_EX_LD: begin
                adr_sel = 1'b1;
                mr_en   = 1'b1;
                sel     = 1'b1;
                W_En    = 1'b1;
            end
            ST_EX_ST: begin
                adr_sel = 1'b1;
                mw_en   = 1'b1;
            end
            ST_EX_BR: begin
                // pc_sel stays 0 so the PC adds the sign-extended offset.
                ld_en = br_taken;
            end
            ST_EX_JR: begin
                pc_sel = 1'b1;
                ld_en  = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_ILLEGAL: begin
                halted  = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
